lfsr_param: RTL and testbench

LFSR_PARAM -- requirements
Module: lfsr_param

---
 rtl/lfsr_param.sv | 105 ++++++++++
 tb/tb_lfsr_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_param.sv
// rtl/lfsr_param.sv - parameterised Fibonacci LFSR with valid/ready output, seed load, warm-up and lock-up recovery
module lfsr_param #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'hD008,
    parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               STEPS  = 1,
    parameter int               WARMUP = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             seed_valid_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             rand_ready_i,
    output logic             rand_valid_o,
    output logic [WIDTH-1:0] rand_o,
    output logic             wrap_o,
    output logic             lockup_o
);

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam fsm_t       RESET_FSM = (WARMUP == 0) ? RUN : WARM;
    localparam logic [7:0] WARM_CNT  = 8'(WARMUP);

    fsm_t             fsm_q, fsm_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_value;
    logic             do_advance;

    // STEPS chained single shifts, unrolled so a whole advance completes in one cycle.
    function automatic logic [WIDTH-1:0] advance_fn(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        for (int i = 0; i < STEPS; i++) begin
            r = {r[WIDTH-2:0], ^(r & TAPS)};
        end
        return r;
    endfunction

    assign next_state = advance_fn(state_q);
    assign load_value = (seed_i == '0) ? SEED : seed_i;
    assign do_advance = (fsm_q == WARM) || rand_ready_i;

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        start_d  = start_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (seed_valid_i) begin
            // A coinciding transfer is treated as consumed; the seed replaces the advance.
            state_d  = load_value;
            start_d  = load_value;
            lockup_d = (seed_i == '0);
            fsm_d    = RESET_FSM;
            cnt_d    = WARM_CNT;
        end else if (state_q == '0) begin
            state_d  = SEED;
            start_d  = SEED;
            lockup_d = 1'b1;
        end else if (do_advance) begin
            state_d = next_state;
            wrap_d  = (next_state == start_q);
            if (fsm_q == WARM) begin
                cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    fsm_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q    <= RESET_FSM;
            cnt_q    <= WARM_CNT;
            state_q  <= SEED;
            start_q  <= SEED;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            start_q  <= start_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign rand_valid_o = (fsm_q == RUN);
    assign rand_o       = state_q;
    assign wrap_o       = wrap_q;
    assign lockup_o     = lockup_q;

endmodule

// File: tb/tb_lfsr_param.sv
// tb/tb_lfsr_param.sv - testbench for lfsr_param: vector table with scoreboard queue plus full-period run
module tb_lfsr_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic [15:0] seed = 16'h0;
    logic        ready = 1'b0;

    logic [2:0]  valid_v;
    logic [15:0] rand_v [3];
    logic [2:0]  wrap_v;
    logic [2:0]  lock_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_param u_def (
        .clk_i(clk), .rst_i(rst), .seed_valid_i(seed_valid), .seed_i(seed),
        .rand_ready_i(ready), .rand_valid_o(valid_v[0]), .rand_o(rand_v[0]),
        .wrap_o(wrap_v[0]), .lockup_o(lock_v[0])
    );

    lfsr_param #(.STEPS(4)) u_s4 (
        .clk_i(clk), .rst_i(rst), .seed_valid_i(seed_valid), .seed_i(seed),
        .rand_ready_i(ready), .rand_valid_o(valid_v[1]), .rand_o(rand_v[1]),
        .wrap_o(wrap_v[1]), .lockup_o(lock_v[1])
    );

    lfsr_param #(.WARMUP(3)) u_w3 (
        .clk_i(clk), .rst_i(rst), .seed_valid_i(seed_valid), .seed_i(seed),
        .rand_ready_i(ready), .rand_valid_o(valid_v[2]), .rand_o(rand_v[2]),
        .wrap_o(wrap_v[2]), .lockup_o(lock_v[2])
    );

    typedef struct {
        string       name;
        int          sel;
        logic        rst;
        logic        sv;
        logic [15:0] seed;
        logic        ready;
        logic [15:0] exp_rand;
        logic        exp_valid;
        logic        exp_wrap;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input string n, input int s, input logic r, input logic v,
                                input logic [15:0] sd, input logic rd, input logic [15:0] er,
                                input logic ev, input logic ew, input logic el);
        vec_t t;
        t.name = n; t.sel = s; t.rst = r; t.sv = v; t.seed = sd; t.ready = rd;
        t.exp_rand = er; t.exp_valid = ev; t.exp_wrap = ew; t.exp_lock = el;
        return t;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb};
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst; seed_valid = v.sv; seed = v.seed; ready = v.ready;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rand_v[e.sel] !== e.exp_rand || valid_v[e.sel] !== e.exp_valid ||
            wrap_v[e.sel] !== e.exp_wrap || lock_v[e.sel] !== e.exp_lock) begin
            failures++;
            $display("FAIL %s: got rand=%h valid=%b wrap=%b lock=%b, expected rand=%h valid=%b wrap=%b lock=%b",
                     e.name, rand_v[e.sel], valid_v[e.sel], wrap_v[e.sel], lock_v[e.sel],
                     e.exp_rand, e.exp_valid, e.exp_wrap, e.exp_lock);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] model;
        int          seq_err;
        int          early_wraps;

        // default instance: reset, free run, backpressure, seed loads
        vecs.push_back(mk("def_reset",      0, 1, 0, 16'h0000, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(mk("def_run1",       0, 0, 0, 16'h0000, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(mk("def_run2",       0, 0, 0, 16'h0000, 1, 16'h0004, 1, 0, 0));
        vecs.push_back(mk("def_run3",       0, 0, 0, 16'h0000, 1, 16'h0008, 1, 0, 0));
        vecs.push_back(mk("def_run4",       0, 0, 0, 16'h0000, 1, 16'h0011, 1, 0, 0));
        vecs.push_back(mk("def_reset2",     0, 1, 0, 16'h0000, 1, 16'h0001, 1, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("def_hold",   0, 0, 0, 16'h0000, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(mk("def_release",    0, 0, 0, 16'h0000, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(mk("def_zero_seed",  0, 0, 1, 16'h0000, 0, 16'h0001, 1, 0, 1));
        vecs.push_back(mk("def_lock_clear", 0, 0, 0, 16'h0000, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(mk("def_zero_rdy",   0, 0, 1, 16'h0000, 1, 16'h0001, 1, 0, 1));
        vecs.push_back(mk("def_lock_clr2",  0, 0, 0, 16'h0000, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(mk("def_seed_rdy",   0, 0, 1, 16'h1234, 1, 16'h1234, 1, 0, 0));
        vecs.push_back(mk("def_seed_adv",   0, 0, 0, 16'h0000, 1, 16'h2469, 1, 0, 0));
        vecs.push_back(mk("def_seed_one",   0, 0, 1, 16'h0001, 0, 16'h0001, 1, 0, 0));
        // STEPS = 4 instance
        vecs.push_back(mk("s4_reset",       1, 1, 0, 16'h0000, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(mk("s4_adv1",        1, 0, 0, 16'h0000, 1, 16'h0011, 1, 0, 0));
        vecs.push_back(mk("s4_adv2",        1, 0, 0, 16'h0000, 1, 16'h0111, 1, 0, 0));
        vecs.push_back(mk("s4_hold",        1, 0, 0, 16'h0000, 0, 16'h0111, 1, 0, 0));
        // WARMUP = 3 instance
        vecs.push_back(mk("w3_reset",       2, 1, 0, 16'h0000, 0, 16'h0001, 0, 0, 0));
        vecs.push_back(mk("w3_warm1",       2, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 0));
        vecs.push_back(mk("w3_warm2",       2, 0, 0, 16'h0000, 0, 16'h0004, 0, 0, 0));
        vecs.push_back(mk("w3_warm3",       2, 0, 0, 16'h0000, 0, 16'h0008, 1, 0, 0));
        vecs.push_back(mk("w3_hold",        2, 0, 0, 16'h0000, 0, 16'h0008, 1, 0, 0));
        vecs.push_back(mk("w3_accept",      2, 0, 0, 16'h0000, 1, 16'h0011, 1, 0, 0));
        vecs.push_back(mk("w3_seed",        2, 0, 1, 16'h0005, 1, 16'h0005, 0, 0, 0));
        vecs.push_back(mk("w3_swarm1",      2, 0, 0, 16'h0000, 0, 16'h000A, 0, 0, 0));
        vecs.push_back(mk("w3_swarm2",      2, 0, 0, 16'h0000, 0, 16'h0015, 0, 0, 0));
        vecs.push_back(mk("w3_swarm3",      2, 0, 0, 16'h0000, 0, 16'h002A, 1, 0, 0));
        vecs.push_back(mk("w3_seed2",       2, 0, 1, 16'h0005, 0, 16'h0005, 0, 0, 0));
        vecs.push_back(mk("w3_midwarm1",    2, 0, 0, 16'h0000, 0, 16'h000A, 0, 0, 0));
        vecs.push_back(mk("w3_mid_reset",   2, 1, 0, 16'h0000, 0, 16'h0001, 0, 0, 0));
        vecs.push_back(mk("w3_rewarm1",     2, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i]);

        // full period of the default sequence with ready held high
        rst = 1'b1; seed_valid = 1'b0; seed = 16'h0; ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        model = 16'h0001;
        seq_err = 0;
        early_wraps = 0;
        for (int i = 1; i <= 65535; i++) begin
            @(posedge clk);
            @(negedge clk);
            model = ref_step(model);
            if (rand_v[0] !== model) seq_err++;
            if (i < 65535 && wrap_v[0] !== 1'b0) early_wraps++;
        end
        checks++;
        if (rand_v[0] !== 16'h0001 || wrap_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL period_end: got rand=%h wrap=%b, expected rand=0001 wrap=1", rand_v[0], wrap_v[0]);
        end
        checks++;
        if (early_wraps != 0) begin
            failures++;
            $display("FAIL early_wrap: got %0d early wrap pulses, expected 0", early_wraps);
        end
        checks++;
        if (seq_err != 0) begin
            failures++;
            $display("FAIL period_seq: got %0d sequence mismatches, expected 0", seq_err);
        end
        ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (wrap_v[0] !== 1'b0 || rand_v[0] !== 16'h0001) begin
            failures++;
            $display("FAIL wrap_single: got rand=%h wrap=%b, expected rand=0001 wrap=0", rand_v[0], wrap_v[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
